// File: rtl/fft_rd_sched_if.sv
// Bus bundle between the FFT read scheduler and its environment: job control,
// memory read channel, fft_fifo control/status and the FFT core handshake.
interface fft_rd_sched_if #(
    parameter int ADDR_W = 42,
    parameter int LEN_W  = 32,
    parameter int CNT_W  = 4
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  num_lines;
    logic              busy;
    logic              done;
    logic              overflow_err;
    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_req_almfull;
    logic              rd_rsp_valid;
    logic              fifo_enq_en;
    logic              fifo_not_full;
    logic [CNT_W-1:0]  fifo_dec_counter;
    logic              fifo_not_empty;
    logic              fifo_deq_en;
    logic              fft_valid;
    logic              fft_ready;
    logic              fft_last;

    modport master (
        input  start, base_addr, num_lines, rd_req_almfull, rd_rsp_valid,
               fifo_not_full, fifo_dec_counter, fifo_not_empty, fft_ready,
        output busy, done, overflow_err, rd_req_valid, rd_req_addr,
               fifo_enq_en, fifo_deq_en, fft_valid, fft_last
    );

    modport slave (
        output start, base_addr, num_lines, rd_req_almfull, rd_rsp_valid,
               fifo_not_full, fifo_dec_counter, fifo_not_empty, fft_ready,
        input  busy, done, overflow_err, rd_req_valid, rd_req_addr,
               fifo_enq_en, fifo_deq_en, fft_valid, fft_last
    );
endinterface

// File: rtl/fft_rd_sched.sv
// FFT input-path read scheduler: credit-throttled line reads into fft_fifo and
// framed drain to the FFT core. Optional perf counters: FFT_RD_SCHED_PERF_EN.
module fft_rd_sched #(
    parameter int FIFO_DEPTH  = 8,
    parameter int ADDR_W      = 42,
    parameter int LEN_W       = 32,
    parameter int FRAME_LINES = 4,
    parameter int CNT_W       = FIFO_DEPTH / 2
) (
    input  logic           clk,
    input  logic           reset_n,
    fft_rd_sched_if.master bus
`ifdef FFT_RD_SCHED_PERF_EN
    ,
    output logic [31:0]    perf_stall_cycles,
    output logic [31:0]    perf_bp_cycles
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO   = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] FRAME_MASK = LEN_W'(FRAME_LINES - 1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   base_r;
    logic [LEN_W-1:0]    num_r;
    logic [LEN_W-1:0]    req_cnt_r;
    logic [LEN_W-1:0]    deq_cnt_r;
    logic [LEN_W-1:0]    out_cnt_r;
    logic                rd_req_valid_r;
    logic [ADDR_W-1:0]   rd_req_addr_r;
    logic                busy_r;
    logic                done_r;
    logic                overflow_r;

    logic                start_acc_s;
    logic                credit_ok_s;
    logic                issue_s;
    logic                rsp_dec_s;
    logic                fft_valid_s;
    logic                xfer_s;
    logic                last_s;
    logic [LEN_W:0]      out_ext_s;
    logic [LEN_W:0]      dec_ext_s;

    // Credit: in-flight reads plus one must stay below the free FIFO slots.
    assign out_ext_s   = {1'b0, out_cnt_r} + {1'b0, LEN_ONE};
    assign dec_ext_s   = {{(LEN_W + 1 - CNT_W){1'b0}}, bus.fifo_dec_counter};
    assign credit_ok_s = out_ext_s < dec_ext_s;

    assign start_acc_s = (state_r == ST_IDLE) && bus.start;
    assign issue_s     = (state_r == ST_RUN) && (req_cnt_r < num_r) &&
                         !bus.rd_req_almfull && credit_ok_s;
    // Late responses from an aborted job must not wrap the in-flight count.
    assign rsp_dec_s   = bus.rd_rsp_valid && (out_cnt_r != LEN_ZERO);
    assign fft_valid_s = bus.fifo_not_empty &&
                         ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    assign xfer_s      = fft_valid_s && bus.fft_ready;
    assign last_s      = fft_valid_s &&
                         (((deq_cnt_r & FRAME_MASK) == FRAME_MASK) ||
                          (deq_cnt_r == (num_r - LEN_ONE)));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = (bus.num_lines == LEN_ZERO) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (req_cnt_r == num_r) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (deq_cnt_r == num_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Job parameters and request/dequeue/in-flight counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r    <= {ADDR_W{1'b0}};
            num_r     <= LEN_ZERO;
            req_cnt_r <= LEN_ZERO;
            deq_cnt_r <= LEN_ZERO;
            out_cnt_r <= LEN_ZERO;
        end else if (start_acc_s) begin
            base_r    <= bus.base_addr;
            num_r     <= bus.num_lines;
            req_cnt_r <= LEN_ZERO;
            deq_cnt_r <= LEN_ZERO;
            out_cnt_r <= LEN_ZERO;
        end else begin
            if (issue_s) begin
                req_cnt_r <= req_cnt_r + LEN_ONE;
            end
            if (xfer_s) begin
                deq_cnt_r <= deq_cnt_r + LEN_ONE;
            end
            case ({issue_s, rsp_dec_s})
                2'b10:   out_cnt_r <= out_cnt_r + LEN_ONE;
                2'b01:   out_cnt_r <= out_cnt_r - LEN_ONE;
                default: out_cnt_r <= out_cnt_r;
            endcase
        end
    end

    // Registered request channel and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_req_valid_r <= 1'b0;
            rd_req_addr_r  <= {ADDR_W{1'b0}};
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            overflow_r     <= 1'b0;
        end else begin
            rd_req_valid_r <= issue_s;
            if (issue_s) begin
                rd_req_addr_r <= base_r + ADDR_W'(req_cnt_r);
            end
            busy_r     <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            done_r     <= (state_nxt_s == ST_DONE);
            overflow_r <= overflow_r | (bus.rd_rsp_valid & ~bus.fifo_not_full);
        end
    end

    assign bus.rd_req_valid = rd_req_valid_r;
    assign bus.rd_req_addr  = rd_req_addr_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.overflow_err = overflow_r;
    assign bus.fifo_enq_en  = bus.rd_rsp_valid;
    assign bus.fft_valid    = fft_valid_s;
    assign bus.fifo_deq_en  = xfer_s;
    assign bus.fft_last     = last_s;

`ifdef FFT_RD_SCHED_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] bp_cnt_r;
    logic        stall_s;
    logic        bp_s;

    assign stall_s = (state_r == ST_RUN) && (req_cnt_r < num_r) && !issue_s;
    assign bp_s    = fft_valid_s && !bus.fft_ready;

    // Saturating stall/backpressure cycle counters, cleared per job.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= 32'd0;
            bp_cnt_r    <= 32'd0;
        end else if (start_acc_s) begin
            stall_cnt_r <= 32'd0;
            bp_cnt_r    <= 32'd0;
        end else begin
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (bp_s && (bp_cnt_r != 32'hFFFF_FFFF)) begin
                bp_cnt_r <= bp_cnt_r + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = stall_cnt_r;
    assign perf_bp_cycles    = bp_cnt_r;
`endif
endmodule

// File: tb/tb_fft_rd_sched.sv
// Self-checking bench for fft_rd_sched: fifo/read-channel environment, a job-level
// reference model compared every cycle, and directed scenarios with literal checks.
module tb_fft_rd_sched;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = 42;
    localparam int LEN_W      = 32;
    localparam int FL         = 4;
    localparam int CNT_W      = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fft_rd_sched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus();

    fft_rd_sched #(
        .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .FRAME_LINES(FL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- environment: fft_fifo occupancy and 2-cycle read latency
    int   occ;
    logic [1:0] rsp_pipe = 2'b00;
    logic inject_rsp = 1'b0;
    logic force_full = 1'b0;

    assign bus.rd_rsp_valid     = rsp_pipe[1] | inject_rsp;
    assign bus.fifo_not_full    = (occ < FIFO_DEPTH - 1) && !force_full;
    assign bus.fifo_dec_counter = CNT_W'(FIFO_DEPTH - occ);
    assign bus.fifo_not_empty   = (occ > 0);

    always @(posedge clk) rsp_pipe <= {rsp_pipe[0], bus.rd_req_valid};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) occ <= 0;
        else occ <= occ + (bus.fifo_enq_en ? 1 : 0) - (bus.fifo_deq_en ? 1 : 0);
    end

    // ---------------- reference model: job phase, line counts, credit
    typedef enum int {P_IDLE, P_ACT, P_DONE} phase_t;
    phase_t            m_phase;
    logic [ADDR_W-1:0] m_base;
    int unsigned       m_num, m_req, m_deq, m_out;
    logic              m_req_valid;
    logic [ADDR_W-1:0] m_req_addr;
    logic              m_ovf;

    logic m_issue, m_rsp_dec, exp_valid, exp_deq, exp_last;
    assign m_issue   = (m_phase == P_ACT) && (m_req < m_num) && !bus.rd_req_almfull &&
                       (int'(m_out) + occ < FIFO_DEPTH - 1);
    assign m_rsp_dec = bus.rd_rsp_valid && (m_out > 0);
    assign exp_valid = (occ > 0) && (m_phase == P_ACT);
    assign exp_deq   = exp_valid && bus.fft_ready;
    assign exp_last  = exp_valid && (((m_deq % FL) == FL - 1) || (m_deq == m_num - 1));

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= P_IDLE; m_base <= '0; m_num <= 0; m_req <= 0; m_deq <= 0;
            m_out <= 0; m_req_valid <= 1'b0; m_req_addr <= '0; m_ovf <= 1'b0;
        end else begin
            m_req_valid <= m_issue;
            if (m_issue) m_req_addr <= m_base + ADDR_W'(m_req);
            m_ovf <= m_ovf | (bus.rd_rsp_valid & ~bus.fifo_not_full);
            if (m_phase == P_IDLE && bus.start) begin
                m_base <= bus.base_addr; m_num <= bus.num_lines;
                m_req <= 0; m_deq <= 0; m_out <= 0;
                m_phase <= (bus.num_lines == 0) ? P_DONE : P_ACT;
            end else begin
                m_req <= m_req + (m_issue ? 1 : 0);
                m_deq <= m_deq + (exp_deq ? 1 : 0);
                m_out <= m_out + (m_issue ? 1 : 0) - (m_rsp_dec ? 1 : 0);
                if (m_phase == P_ACT && m_deq == m_num) m_phase <= P_DONE;
                else if (m_phase == P_DONE) m_phase <= P_IDLE;
            end
        end
    end

    // ---------------- per-cycle compare and observation tallies
    int   obs_req = 0, obs_deq = 0, obs_done = 0, hold_req = 0;
    logic hold_win = 1'b0;
    logic [63:0] last_shift = 64'd0;
    logic [ADDR_W-1:0] last_addr = '0;

    always @(negedge clk) begin
        check_bit("rd_req_valid", bus.rd_req_valid, m_req_valid);
        if (m_req_valid) check_val("rd_req_addr", 64'(bus.rd_req_addr), 64'(m_req_addr));
        check_bit("fifo_enq_en", bus.fifo_enq_en, bus.rd_rsp_valid);
        check_bit("fft_valid", bus.fft_valid, exp_valid);
        check_bit("fifo_deq_en", bus.fifo_deq_en, exp_deq);
        check_bit("fft_last", bus.fft_last, exp_last);
        check_bit("busy", bus.busy, m_phase == P_ACT);
        check_bit("done", bus.done, m_phase == P_DONE);
        check_bit("overflow_err", bus.overflow_err, m_ovf);
        if (bus.rd_req_valid) begin
            obs_req   <= obs_req + 1;
            last_addr <= bus.rd_req_addr;
        end
        if (bus.rd_req_valid && hold_win) hold_req <= hold_req + 1;
        if (bus.fifo_deq_en) begin
            obs_deq    <= obs_deq + 1;
            last_shift <= {last_shift[62:0], bus.fft_last};
        end
        if (bus.done) obs_done <= obs_done + 1;
    end

    // ---------------- directed stimulus
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [ADDR_W-1:0] base, input int unsigned num);
        bus.base_addr = base;
        bus.num_lines = num;
        bus.start     = 1'b1;
        tick(1);
        bus.start     = 1'b0;
        bus.num_lines = 32'd7;
        bus.base_addr = 42'h0AB_CDEF;
    endtask

    task automatic wait_done(input string name, input int limit);
        int  base_done = obs_done;
        bit  seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            tick(1);
            if (obs_done != base_done) seen = 1'b1;
        end
        check_bit(name, seen, 1'b1);
    endtask

    int s_req, s_deq, s_done;

    task automatic snap();
        s_req = obs_req; s_deq = obs_deq; s_done = obs_done;
    endtask

    initial begin
        bus.start = 1'b0; bus.base_addr = '0; bus.num_lines = '0;
        bus.rd_req_almfull = 1'b0; bus.fft_ready = 1'b1;
        tick(3);
        check_bit("rst_req_valid", bus.rd_req_valid, 1'b0);
        check_bit("rst_busy", bus.busy, 1'b0);
        check_bit("rst_done", bus.done, 1'b0);
        check_bit("rst_fft_valid", bus.fft_valid, 1'b0);
        check_bit("rst_ovf", bus.overflow_err, 1'b0);
        reset_n = 1'b1;
        tick(2);

        // basic job, with an ignored start mid-job
        snap();
        start_job(42'h100, 10);
        tick(5);
        start_job(42'h999, 3);
        wait_done("job1_done_timeout", 200);
        check_val("job1_reqs", 64'(obs_req - s_req), 64'd10);
        check_val("job1_deqs", 64'(obs_deq - s_deq), 64'd10);
        check_val("job1_last_pattern", {54'd0, last_shift[9:0]}, 64'h045);
        check_val("job1_last_addr", 64'(last_addr), 64'h109);
        check_val("job1_done_pulses", 64'(obs_done - s_done), 64'd1);
        check_bit("job1_ovf", bus.overflow_err, 1'b0);
        tick(2);

        // FFT core stalled: credit caps requests at FIFO_DEPTH-1
        bus.fft_ready = 1'b0;
        snap();
        start_job(42'h2000, 20);
        tick(40);
        check_val("stall_reqs", 64'(obs_req - s_req), 64'd7);
        check_bit("stall_busy", bus.busy, 1'b1);
        bus.fft_ready = 1'b1;
        wait_done("job2_done_timeout", 300);
        check_val("job2_reqs", 64'(obs_req - s_req), 64'd20);
        check_val("job2_deqs", 64'(obs_deq - s_deq), 64'd20);
        check_val("job2_last_addr", 64'(last_addr), 64'h2013);
        tick(2);

        // almfull held for 50 cycles mid-job
        snap();
        start_job(42'h3000, 30);
        tick(5);
        bus.rd_req_almfull = 1'b1;
        tick(1);
        hold_win = 1'b1;
        tick(49);
        hold_win = 1'b0;
        bus.rd_req_almfull = 1'b0;
        tick(1);
        check_val("almfull_hold_reqs", 64'(hold_req), 64'd0);
        check_bit("almfull_resume", bus.rd_req_valid, 1'b1);
        wait_done("job3_done_timeout", 400);
        check_val("job3_reqs", 64'(obs_req - s_req), 64'd30);
        tick(2);

        // zero-length job
        snap();
        start_job(42'h4000, 0);
        check_bit("zero_done", bus.done, 1'b1);
        tick(1);
        check_bit("zero_done_clear", bus.done, 1'b0);
        tick(3);
        check_val("zero_reqs", 64'(obs_req - s_req), 64'd0);

        // address wrap, job ends mid-frame
        snap();
        start_job(42'h3FF_FFFF_FFFE, 5);
        wait_done("wrap_done_timeout", 200);
        check_val("wrap_last_addr", 64'(last_addr), 64'h2);
        check_val("wrap_last_pattern", {59'd0, last_shift[4:0]}, 64'h3);
        tick(2);

        // reset mid-RUN, then a clean job
        start_job(42'h5000, 20);
        tick(4);
        reset_n = 1'b0;
        #1;
        check_bit("abort_req_valid", bus.rd_req_valid, 1'b0);
        check_bit("abort_busy", bus.busy, 1'b0);
        check_bit("abort_fft_valid", bus.fft_valid, 1'b0);
        check_bit("abort_deq", bus.fifo_deq_en, 1'b0);
        check_bit("abort_last", bus.fft_last, 1'b0);
        tick(3);
        reset_n = 1'b1;
        tick(2);
        snap();
        start_job(42'h6000, 6);
        wait_done("job_after_reset_timeout", 200);
        check_val("post_reset_reqs", 64'(obs_req - s_req), 64'd6);
        check_val("post_reset_deqs", 64'(obs_deq - s_deq), 64'd6);
        check_val("post_reset_last_addr", 64'(last_addr), 64'h6005);
        check_val("post_reset_last_pattern", {58'd0, last_shift[5:0]}, 64'h05);
        tick(2);

        // response arriving while FIFO reports full
        force_full = 1'b1;
        inject_rsp = 1'b1;
        tick(1);
        inject_rsp = 1'b0;
        force_full = 1'b0;
        check_bit("ovf_set", bus.overflow_err, 1'b1);
        tick(5);
        check_bit("ovf_sticky", bus.overflow_err, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
